// File: rtl/legv8_cw_sequencer.sv
// ---------------------------------------------------------------------------
// legv8_cw_sequencer
//
// Purpose:
//   This is a program store of control words for the LEGv8 datapath. Each
//   entry holds a control word, a constant and two flags:
//     - last: the entry ends the program.
//     - wait: a stall may hold the entry.
//   While the sequencer is in IDLE, the control/test logic loads entries and
//   then issues start. The sequencer then issues one entry per clock, starting
//   at entry 0. It captures the datapath status flags in a one-cycle DONE state
//   when the program ends.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-high reset (the store is not reset)
//   load_en       write one program entry (accepted only in IDLE, and only
//                 when start is low)
//   load_addr     index of the entry to write
//   load_cw       control word for the entry
//   load_const    constant for the entry
//   load_last     entry ends the program
//   load_wait     stall may hold the entry
//   start         begin at entry 0 (accepted only in IDLE)
//   stall         memory not ready; holds an entry that has wait set
//   abort         return to IDLE at once, with no done pulse
//   status        datapath status flags
//   ControlWord   registered control word (0 = NOP when not running)
//   constant      registered constant
//   pc            index of the entry now on ControlWord
//   busy          high while running
//   done          one-cycle pulse at program completion
//   final_status  status captured at the completion edge
// ---------------------------------------------------------------------------
module legv8_cw_sequencer #(
  parameter int CW_WIDTH    = 32,
  parameter int CONST_WIDTH = 64,
  parameter int DEPTH       = 16,
  parameter int PC_W        = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [PC_W-1:0]        load_addr,
  input  logic [CW_WIDTH-1:0]    load_cw,
  input  logic [CONST_WIDTH-1:0] load_const,
  input  logic                   load_last,
  input  logic                   load_wait,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   abort,
  input  logic [3:0]             status,
  output logic [CW_WIDTH-1:0]    ControlWord,
  output logic [CONST_WIDTH-1:0] constant,
  output logic [PC_W-1:0]        pc,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             final_status
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_FIRST = '0;
  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(DEPTH - 1);

  // Program store: no reset, so its contents survive a reset of the sequencer.
  logic [CW_WIDTH-1:0]    cw_mem    [DEPTH];
  logic [CONST_WIDTH-1:0] const_mem [DEPTH];
  logic                   last_mem  [DEPTH];
  logic                   wait_mem  [DEPTH];

  state_t                 state_q, state_d;
  logic [CW_WIDTH-1:0]    cw_q, cw_d;
  logic [CONST_WIDTH-1:0] const_q, const_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [3:0]             fstat_q, fstat_d;

  logic                   mem_we;
  logic [PC_W-1:0]        pc_next;
  logic                   cur_last;
  logic                   cur_wait;

  assign pc_next  = pc_q + PC_W'(1);
  assign cur_last = last_mem[pc_q];
  assign cur_wait = wait_mem[pc_q];

  // The write port is written by the control process, so an ignored load
  // (in RUN or DONE, or a load that loses to start) never touches the store.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      cw_mem[load_addr]    <= load_cw;
      const_mem[load_addr] <= load_const;
      last_mem[load_addr]  <= load_last;
      wait_mem[load_addr]  <= load_wait;
    end
  end

  // State register and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cw_q    <= '0;
      const_q <= '0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fstat_q <= '0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      const_q <= const_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fstat_q <= fstat_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    const_d = const_q;
    pc_d    = pc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fstat_d = fstat_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cw_d    = '0;
        const_d = '0;
        pc_d    = '0;
        busy_d  = 1'b0;
        if (start) begin
          // start beats a simultaneous load; entry 0 goes out right away.
          state_d = S_RUN;
          busy_d  = 1'b1;
          cw_d    = cw_mem[PC_FIRST];
          const_d = const_mem[PC_FIRST];
        end else if (load_en) begin
          mem_we = 1'b1;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cw_d    = '0;
          const_d = '0;
          pc_d    = '0;
          busy_d  = 1'b0;
        end else if (cur_wait && stall) begin
          // Hold: pc, ControlWord and constant keep their values.
          state_d = S_RUN;
        end else if (cur_last || (pc_q == PC_LAST)) begin
          // Running off the end of the store also terminates the program;
          // pc never wraps to 0.
          state_d = S_DONE;
          cw_d    = '0;
          const_d = '0;
          pc_d    = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          fstat_d = status;
        end else begin
          pc_d    = pc_next;
          cw_d    = cw_mem[pc_next];
          const_d = const_mem[pc_next];
        end
      end

      S_DONE: begin
        // One cycle only; start arriving here is ignored.
        state_d = S_IDLE;
        cw_d    = '0;
        const_d = '0;
        pc_d    = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        cw_d    = '0;
        const_d = '0;
        pc_d    = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign ControlWord  = cw_q;
  assign constant     = const_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign final_status = fstat_q;

endmodule

// File: tb/tb_legv8_cw_sequencer.sv
module tb_legv8_cw_sequencer;

  localparam int CW_WIDTH    = 32;
  localparam int CONST_WIDTH = 64;
  localparam int DEPTH       = 4;
  localparam int PC_W        = 2;

  logic                   clock;
  logic                   reset;
  logic                   load_en;
  logic [PC_W-1:0]        load_addr;
  logic [CW_WIDTH-1:0]    load_cw;
  logic [CONST_WIDTH-1:0] load_const;
  logic                   load_last;
  logic                   load_wait;
  logic                   start;
  logic                   stall;
  logic                   abort;
  logic [3:0]             status;
  logic [CW_WIDTH-1:0]    ControlWord;
  logic [CONST_WIDTH-1:0] constant;
  logic [PC_W-1:0]        pc;
  logic                   busy;
  logic                   done;
  logic [3:0]             final_status;

  int n_vec;
  int n_miss;

  logic [31:0] exp_cw    [4];
  logic [63:0] exp_const [4];

  legv8_cw_sequencer #(
    .CW_WIDTH    (CW_WIDTH),
    .CONST_WIDTH (CONST_WIDTH),
    .DEPTH       (DEPTH),
    .PC_W        (PC_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_cw      (load_cw),
    .load_const   (load_const),
    .load_last    (load_last),
    .load_wait    (load_wait),
    .start        (start),
    .stall        (stall),
    .abort        (abort),
    .status       (status),
    .ControlWord  (ControlWord),
    .constant     (constant),
    .pc           (pc),
    .busy         (busy),
    .done         (done),
    .final_status (final_status)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [1:0] a, input logic [31:0] c, input logic [63:0] k,
                         input logic l, input logic w);
    load_addr  = a;
    load_cw    = c;
    load_const = k;
    load_last  = l;
    load_wait  = w;
    load_en    = 1'b1;
    tick();
    load_en    = 1'b0;
  endtask

  task automatic check_entry(input string tag, input int k);
    chk({tag, ".cw"},    64'(ControlWord), 64'(exp_cw[k]));
    chk({tag, ".const"}, constant,         exp_const[k]);
    chk({tag, ".pc"},    64'(pc),          64'(k));
    chk({tag, ".busy"},  64'(busy),        64'd1);
    chk({tag, ".done"},  64'(done),        64'd0);
  endtask

  task automatic check_done(input string tag, input logic [3:0] fs);
    chk({tag, ".cw"},    64'(ControlWord),  64'd0);
    chk({tag, ".const"}, constant,          64'd0);
    chk({tag, ".pc"},    64'(pc),           64'd0);
    chk({tag, ".busy"},  64'(busy),         64'd0);
    chk({tag, ".done"},  64'(done),         64'd1);
    chk({tag, ".fstat"}, 64'(final_status), 64'(fs));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".cw"},    64'(ControlWord),  64'd0);
    chk({tag, ".const"}, constant,          64'd0);
    chk({tag, ".pc"},    64'(pc),           64'd0);
    chk({tag, ".busy"},  64'(busy),         64'd0);
    chk({tag, ".done"},  64'(done),         64'd0);
    chk({tag, ".fstat"}, 64'(final_status), 64'd0);
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    clock      = 1'b0;
    reset      = 1'b0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_cw    = '0;
    load_const = '0;
    load_last  = 1'b0;
    load_wait  = 1'b0;
    start      = 1'b0;
    stall      = 1'b0;
    abort      = 1'b0;
    status     = 4'd0;

    exp_cw[0] = 32'h00101041; exp_const[0] = 64'd24;
    exp_cw[1] = 32'h00290401; exp_const[1] = 64'd0;
    exp_cw[2] = 32'h00000001; exp_const[2] = 64'd0;
    exp_cw[3] = 32'hAAAA0003; exp_const[3] = 64'd3;

    // Reset asserted between edges: outputs must clear immediately.
    #3 reset = 1'b1;
    #1 check_reset("rst_async");
    tick();
    tick();
    reset = 1'b0;

    do_load(2'd0, 32'h00101041, 64'd24, 1'b0, 1'b0);
    do_load(2'd1, 32'h00290401, 64'd0,  1'b0, 1'b0);
    do_load(2'd2, 32'h00000001, 64'd0,  1'b1, 1'b0);
    do_load(2'd3, 32'hAAAA0003, 64'd3,  1'b0, 1'b0);

    // Three-entry program, started together with a load that must be dropped.
    load_addr  = 2'd0;
    load_cw    = 32'hDEADBEEF;
    load_const = 64'd99;
    load_last  = 1'b1;
    load_en    = 1'b1;
    start      = 1'b1;
    tick();
    start   = 1'b0;
    load_en = 1'b0;
    check_entry("p3_e0", 0);
    tick();
    check_entry("p3_e1", 1);
    status = 4'b0100;
    tick();
    check_entry("p3_e2", 2);
    tick();
    check_done("p3_done", 4'b0100);
    status = 4'd0;
    tick();
    chk("p3_after.done",  64'(done),         64'd0);
    chk("p3_after.fstat", 64'(final_status), 64'h4);

    // Stall on a wait entry: entry1 held for 4 cycles, done 3 cycles late.
    do_load(2'd1, 32'h00290401, 64'd0, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_entry("st_e0", 0);
    tick();
    check_entry("st_e1", 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_entry("st_hold", 1);
    end
    stall  = 1'b0;
    status = 4'b1010;
    tick();
    check_entry("st_e2", 2);
    tick();
    check_done("st_done", 4'b1010);
    status = 4'd0;
    tick();

    // Same program with wait cleared: stall has no effect.
    do_load(2'd1, 32'h00290401, 64'd0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_entry("nw_e0", 0);
    stall = 1'b1;
    tick();
    check_entry("nw_e1", 1);
    tick();
    check_entry("nw_e2", 2);
    status = 4'b0011;
    tick();
    check_done("nw_done", 4'b0011);
    stall  = 1'b0;
    status = 4'd0;
    tick();

    // Abort during entry1 of a four-entry program.
    do_load(2'd2, 32'h00000001, 64'd0, 1'b0, 1'b0);
    do_load(2'd3, 32'hAAAA0003, 64'd3, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_entry("ab_e0", 0);
    tick();
    check_entry("ab_e1", 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab.cw",   64'(ControlWord), 64'd0);
    chk("ab.busy", 64'(busy),        64'd0);
    chk("ab.pc",   64'(pc),          64'd0);
    chk("ab.done", 64'(done),        64'd0);
    status = 4'hF;
    tick();
    chk("ab_after.done",  64'(done),         64'd0);
    chk("ab_after.fstat", 64'(final_status), 64'h3);
    status = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_entry("ab_replay", k);
      if (k == 3) status = 4'b1000;
      tick();
    end
    check_done("ab_replay_done", 4'b1000);
    status = 4'd0;
    tick();

    // Run off the end (no last flags); a load during RUN must be ignored.
    do_load(2'd3, 32'hAAAA0003, 64'd3, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_entry("roe_e0", 0);
    load_addr  = 2'd2;
    load_cw    = 32'h55555555;
    load_const = 64'd5;
    load_last  = 1'b1;
    load_en    = 1'b1;
    tick();
    load_en = 1'b0;
    check_entry("roe_e1", 1);
    tick();
    check_entry("roe_e2", 2);
    tick();
    check_entry("roe_e3", 3);
    status = 4'b0110;
    tick();
    check_done("roe_done", 4'b0110);
    status = 4'd0;
    tick();

    // Rerun, then reset during entry2.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_entry("rr_e0", 0);
    tick();
    check_entry("rr_e1", 1);
    tick();
    check_entry("rr_e2", 2);
    #2 reset = 1'b1;
    #1 check_reset("rst_mid");
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_entry("post_rst", k);
      if (k == 3) status = 4'b0001;
      tick();
    end
    check_done("post_rst_done", 4'b0001);
    status = 4'd0;
    tick();
    chk("post_rst_idle.done", 64'(done), 64'd0);
    chk("post_rst_idle.busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
